// File: rtl/zube_mbox.sv
// Z80 <-> Wishbone mailbox: per-channel byte FIFOs in both directions, a maskable
// sticky IRQ scheme, overflow/underflow flags and an optional Z80 interrupt.
module zube_mbox #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          NUM_CHANNELS = 2,
    parameter int          DEPTH_BITS   = 4,
    parameter logic [7:0]  Z80_BASE_RST = 8'h80
) (
    input  logic        clk,
    input  logic        reset_b,
    input  logic        z80_write_strobe_b,
    input  logic        z80_read_strobe_b,
    input  logic        z80_ioreq_b,
    input  logic        z80_m1,
    input  logic [7:0]  z80_address_bus,
    input  logic [7:0]  z80_data_bus_in,
    output logic [7:0]  z80_data_bus_out,
    output logic        z80_bus_dir,
    output logic        z80_int_b,
    input  logic        wb_cyc_in,
    input  logic        wb_stb_in,
    input  logic        wb_we_in,
    input  logic [31:0] wb_addr_in,
    input  logic [31:0] wb_data_in,
    output logic        wb_ack_out,
    output logic [31:0] wb_data_out,
    output logic        irq_out
);

    localparam int DEPTH = 1 << DEPTH_BITS;

    logic       rd_s1, rd_s2, rd_s3, wr_s1, wr_s2, wr_s3;
    logic [7:0] z_addr_s1, z_addr_s2, z_data_s1, z_data_s2;
    logic       rd_rise, rd_fall, wr_rise;
    logic [7:0] z_off;
    logic       z_data_hit, z_stat_hit;
    logic       driven, rd_pop_arm;
    logic [1:0] rd_ch;

    logic [7:0] z80_base;
    logic       int_en;
    logic [7:0] pending, enable, pend_set;
    logic [NUM_CHANNELS-1:0] err_ovf, err_unf;

    logic [NUM_CHANNELS-1:0] z2a_push, z2a_pop, a2z_push, a2z_pop;
    logic [NUM_CHANNELS-1:0] z2a_full, z2a_ne, a2z_full, a2z_ne;
    logic [NUM_CHANNELS-1:0] z_ovf_set, z_unf_set, wb_ovf_set;
    logic [7:0]              z2a_head [NUM_CHANNELS];
    logic [7:0]              a2z_head [NUM_CHANNELS];
    logic [3:0]              z2a_ne4, z2a_full4, a2z_ne4, a2z_full4, ovf4, unf4;

    logic        wb_hit, wb_fire, wb_data_sel, wb_rd_pop, wb_pend_w1c, wb_err_clr;
    logic [4:0]  wb_off;
    logic [1:0]  wb_ch;
    logic [31:0] wb_rdata;
    logic [7:0]  z_rd_head, wb_rd_head;
    logic        z_rd_ne, wb_rd_ne;
    logic        wb_unused;

    assign rd_rise = rd_s2 & ~rd_s3;
    assign rd_fall = ~rd_s2 & rd_s3;
    assign wr_rise = wr_s2 & ~wr_s3;

    assign z_off      = z_addr_s2 - z80_base;
    assign z_data_hit = z_off < 8'(NUM_CHANNELS);
    assign z_stat_hit = z_off == 8'(NUM_CHANNELS);
    assign z80_bus_dir = driven & ~z80_read_strobe_b;

    assign z2a_ne4   = 4'(z2a_ne);
    assign z2a_full4 = 4'(z2a_full);
    assign a2z_ne4   = 4'(a2z_ne);
    assign a2z_full4 = 4'(a2z_full);
    assign ovf4      = 4'(err_ovf);
    assign unf4      = 4'(err_unf);

    // Wishbone classic: a hit (cyc & stb & in-window) is answered by a one-cycle
    // registered ack; every side effect happens in that ack cycle, and ack always
    // drops for a cycle so a held strobe is seen as a fresh access.
    assign wb_hit      = wb_cyc_in & wb_stb_in & (wb_addr_in[31:5] == BASE_ADDRESS[31:5]);
    assign wb_fire     = wb_ack_out & wb_hit;
    assign wb_off      = wb_addr_in[4:0];
    assign wb_ch       = wb_off[3:2];
    assign wb_data_sel = wb_off[4] & (wb_off[1:0] == 2'b00) &
                         ({1'b0, wb_off[3:2]} < 3'(NUM_CHANNELS));
    assign wb_pend_w1c = wb_fire & wb_we_in & (wb_off == 5'h08);
    assign wb_err_clr  = wb_pend_w1c & wb_data_in[16];
    assign wb_unused   = ^{wb_data_in[31:17], wb_data_in[15:9]};

    always_comb begin
        z2a_push   = '0;
        z2a_pop    = '0;
        a2z_push   = '0;
        a2z_pop    = '0;
        z_ovf_set  = '0;
        z_unf_set  = '0;
        wb_ovf_set = '0;
        pend_set   = '0;
        z_rd_head  = 8'hFF;
        z_rd_ne    = 1'b0;
        wb_rd_head = 8'hFF;
        wb_rd_ne   = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (z_off == 8'(i)) begin
                z_rd_head = a2z_head[i];
                z_rd_ne   = a2z_ne[i];
            end
            if (wb_ch == 2'(i)) begin
                wb_rd_head = z2a_head[i];
                wb_rd_ne   = z2a_ne[i];
            end
            z2a_pop[i]    = wb_fire & ~wb_we_in & wb_data_sel & (wb_ch == 2'(i)) & wb_rd_pop;
            a2z_pop[i]    = rd_fall & rd_pop_arm & (rd_ch == 2'(i));
            // A full FIFO still takes a push when a pop lands in the same cycle.
            z2a_push[i]   = wr_rise & (z_off == 8'(i)) & (~z2a_full[i] | z2a_pop[i]);
            z_ovf_set[i]  = wr_rise & (z_off == 8'(i)) & z2a_full[i] & ~z2a_pop[i];
            a2z_push[i]   = wb_fire & wb_we_in & wb_data_sel & (wb_ch == 2'(i)) &
                            (~a2z_full[i] | a2z_pop[i]);
            wb_ovf_set[i] = wb_fire & wb_we_in & wb_data_sel & (wb_ch == 2'(i)) &
                            a2z_full[i] & ~a2z_pop[i];
            z_unf_set[i]  = rd_rise & (z_off == 8'(i)) & ~a2z_ne[i];
            pend_set[i]     = z2a_push[i];
            pend_set[4 + i] = a2z_pop[i];
        end
    end

    always_comb begin
        wb_rdata = '0;
        if (wb_data_sel) begin
            wb_rdata = {24'h0, wb_rd_ne ? wb_rd_head : 8'hFF};
        end else begin
            case (wb_off)
                5'h00:   wb_rdata = {23'h0, int_en, z80_base};
                5'h04:   wb_rdata = {16'h0, unf4, ovf4, a2z_full4, z2a_ne4};
                5'h08:   wb_rdata = {24'h0, pending};
                5'h0C:   wb_rdata = {24'h0, enable};
                default: wb_rdata = '0;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic [7:0]            z2a_mem [DEPTH];
        logic [7:0]            a2z_mem [DEPTH];
        logic [DEPTH_BITS-1:0] z2a_wp, z2a_rp, a2z_wp, a2z_rp;
        logic [DEPTH_BITS:0]   z2a_cnt, a2z_cnt;

        always_ff @(posedge clk) begin
            if (z2a_push[g]) z2a_mem[z2a_wp] <= z_data_s2;
            if (a2z_push[g]) a2z_mem[a2z_wp] <= wb_data_in[7:0];
        end

        always_ff @(posedge clk or negedge reset_b) begin
            if (!reset_b) begin
                z2a_wp  <= '0;
                z2a_rp  <= '0;
                z2a_cnt <= '0;
                a2z_wp  <= '0;
                a2z_rp  <= '0;
                a2z_cnt <= '0;
            end else begin
                if (z2a_push[g]) z2a_wp <= z2a_wp + 1'b1;
                if (z2a_pop[g])  z2a_rp <= z2a_rp + 1'b1;
                if (z2a_push[g] && !z2a_pop[g])      z2a_cnt <= z2a_cnt + 1'b1;
                else if (!z2a_push[g] && z2a_pop[g]) z2a_cnt <= z2a_cnt - 1'b1;
                if (a2z_push[g]) a2z_wp <= a2z_wp + 1'b1;
                if (a2z_pop[g])  a2z_rp <= a2z_rp + 1'b1;
                if (a2z_push[g] && !a2z_pop[g])      a2z_cnt <= a2z_cnt + 1'b1;
                else if (!a2z_push[g] && a2z_pop[g]) a2z_cnt <= a2z_cnt - 1'b1;
            end
        end

        // Count tops out at exactly DEPTH, so its MSB alone means full.
        assign z2a_full[g] = z2a_cnt[DEPTH_BITS];
        assign a2z_full[g] = a2z_cnt[DEPTH_BITS];
        assign z2a_ne[g]   = z2a_cnt != '0;
        assign a2z_ne[g]   = a2z_cnt != '0;
        assign z2a_head[g] = z2a_mem[z2a_rp];
        assign a2z_head[g] = a2z_mem[a2z_rp];
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rd_s1            <= 1'b0;
            rd_s2            <= 1'b0;
            rd_s3            <= 1'b0;
            wr_s1            <= 1'b0;
            wr_s2            <= 1'b0;
            wr_s3            <= 1'b0;
            z_addr_s1        <= '0;
            z_addr_s2        <= '0;
            z_data_s1        <= '0;
            z_data_s2        <= '0;
            driven           <= 1'b0;
            rd_pop_arm       <= 1'b0;
            rd_ch            <= '0;
            z80_data_bus_out <= '0;
            z80_base         <= Z80_BASE_RST;
            int_en           <= 1'b0;
            pending          <= '0;
            enable           <= '0;
            err_ovf          <= '0;
            err_unf          <= '0;
            wb_ack_out       <= 1'b0;
            wb_data_out      <= '0;
            wb_rd_pop        <= 1'b0;
            irq_out          <= 1'b0;
            z80_int_b        <= 1'b1;
        end else begin
            rd_s1     <= z80_m1 & ~z80_ioreq_b & ~z80_read_strobe_b;
            rd_s2     <= rd_s1;
            rd_s3     <= rd_s2;
            wr_s1     <= z80_m1 & ~z80_ioreq_b & ~z80_write_strobe_b;
            wr_s2     <= wr_s1;
            wr_s3     <= wr_s2;
            z_addr_s1 <= z80_address_bus;
            z_addr_s2 <= z_addr_s1;
            z_data_s1 <= z80_data_bus_in;
            z_data_s2 <= z_data_s1;

            // rd_ch remembers the channel so a base change mid-cycle still pops it.
            if (rd_rise && z_data_hit) begin
                driven           <= 1'b1;
                rd_ch            <= z_off[1:0];
                rd_pop_arm       <= z_rd_ne;
                z80_data_bus_out <= z_rd_ne ? z_rd_head : 8'hFF;
            end else if (rd_rise && z_stat_hit) begin
                driven           <= 1'b1;
                rd_pop_arm       <= 1'b0;
                z80_data_bus_out <= {z2a_full4, a2z_ne4};
            end else if (rd_fall) begin
                driven     <= 1'b0;
                rd_pop_arm <= 1'b0;
            end

            err_ovf <= (err_ovf & {NUM_CHANNELS{~wb_err_clr}}) | z_ovf_set | wb_ovf_set;
            err_unf <= (err_unf & {NUM_CHANNELS{~wb_err_clr}}) | z_unf_set;
            pending <= (wb_pend_w1c ? (pending & ~wb_data_in[7:0]) : pending) | pend_set;

            if (wb_fire && wb_we_in && wb_off == 5'h00) begin
                z80_base <= wb_data_in[7:0];
                int_en   <= wb_data_in[8];
            end
            if (wb_fire && wb_we_in && wb_off == 5'h0C) enable <= wb_data_in[7:0];

            // Read data and the pop decision are captured together one cycle before ack.
            wb_ack_out <= wb_hit & ~wb_ack_out;
            if (wb_hit && !wb_ack_out) begin
                wb_data_out <= wb_rdata;
                wb_rd_pop   <= ~wb_we_in & wb_data_sel & wb_rd_ne;
            end else begin
                wb_data_out <= '0;
                wb_rd_pop   <= 1'b0;
            end

            irq_out   <= |(pending & enable);
            z80_int_b <= ~(int_en & |a2z_ne);
        end
    end

endmodule

// File: tb/tb_zube_mbox.sv
// Directed bench for zube_mbox: expected read data goes into queues and two
// monitors compare whatever the DUT presents on the Wishbone and Z80 sides.
module tb_zube_mbox;

    logic        clk;
    logic        reset_b;
    logic        z80_write_strobe_b, z80_read_strobe_b, z80_ioreq_b, z80_m1;
    logic [7:0]  z80_address_bus, z80_data_bus_in, z80_data_bus_out;
    logic        z80_bus_dir, z80_int_b;
    logic        wb_cyc_in, wb_stb_in, wb_we_in;
    logic [31:0] wb_addr_in, wb_data_in, wb_data_out;
    logic        wb_ack_out, irq_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wb_exp_q[$];
    string       wb_name_q[$];
    logic [7:0]  z80_exp_q[$];
    string       z80_name_q[$];
    logic        prev_dir = 1'b0;

    zube_mbox dut (
        .clk                (clk),
        .reset_b            (reset_b),
        .z80_write_strobe_b (z80_write_strobe_b),
        .z80_read_strobe_b  (z80_read_strobe_b),
        .z80_ioreq_b        (z80_ioreq_b),
        .z80_m1             (z80_m1),
        .z80_address_bus    (z80_address_bus),
        .z80_data_bus_in    (z80_data_bus_in),
        .z80_data_bus_out   (z80_data_bus_out),
        .z80_bus_dir        (z80_bus_dir),
        .z80_int_b          (z80_int_b),
        .wb_cyc_in          (wb_cyc_in),
        .wb_stb_in          (wb_stb_in),
        .wb_we_in           (wb_we_in),
        .wb_addr_in         (wb_addr_in),
        .wb_data_in         (wb_data_in),
        .wb_ack_out         (wb_ack_out),
        .wb_data_out        (wb_data_out),
        .irq_out            (irq_out)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        if (wb_ack_out && !wb_we_in) begin
            if (wb_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL wb_unexpected_ack: got data 0x%0h with nothing expected", wb_data_out);
            end else begin
                check(wb_name_q.pop_front(), wb_data_out, wb_exp_q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (z80_bus_dir && !prev_dir) begin
            if (z80_exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL z80_unexpected_drive: got 0x%0h with nothing expected", z80_data_bus_out);
            end else begin
                check(z80_name_q.pop_front(), 32'(z80_data_bus_out), 32'(z80_exp_q.pop_front()));
            end
        end
        prev_dir = z80_bus_dir;
    end

    // Wishbone driver
    task automatic wb_access(input logic we, input logic [4:0] off, input logic [31:0] wdata);
        logic got;
        @(negedge clk);
        wb_cyc_in  = 1'b1;
        wb_stb_in  = 1'b1;
        wb_we_in   = we;
        wb_addr_in = 32'h3000_0000 | {27'h0, off};
        wb_data_in = wdata;
        got = 1'b0;
        for (int n = 0; n < 4 && !got; n++) begin
            @(posedge clk);
            #1;
            got = wb_ack_out;
        end
        check("wb_ack_seen", 32'(got), 32'd1);
        if (got) begin
            @(posedge clk);
            #1;
            check("wb_ack_one_cycle", 32'(wb_ack_out), 32'd0);
        end
        wb_cyc_in = 1'b0;
        wb_stb_in = 1'b0;
        wb_we_in  = 1'b0;
    endtask

    task automatic wb_write(input logic [4:0] off, input logic [31:0] wdata);
        wb_access(1'b1, off, wdata);
    endtask

    task automatic wb_read(input logic [4:0] off, input logic [31:0] exp, input string name);
        wb_exp_q.push_back(exp);
        wb_name_q.push_back(name);
        wb_access(1'b0, off, 32'h0);
    endtask

    // Z80 driver
    task automatic z80_out(input logic [7:0] port, input logic [7:0] data);
        @(negedge clk);
        z80_address_bus    = port;
        z80_data_bus_in    = data;
        z80_ioreq_b        = 1'b0;
        z80_write_strobe_b = 1'b0;
        repeat (4) @(negedge clk);
        z80_write_strobe_b = 1'b1;
        z80_ioreq_b        = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic z80_rd_start(input logic [7:0] port, input logic [7:0] exp, input string name);
        z80_exp_q.push_back(exp);
        z80_name_q.push_back(name);
        @(negedge clk);
        z80_address_bus   = port;
        z80_ioreq_b       = 1'b0;
        z80_read_strobe_b = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic z80_rd_end();
        z80_read_strobe_b = 1'b1;
        z80_ioreq_b       = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic z80_in(input logic [7:0] port, input logic [7:0] exp, input string name);
        z80_rd_start(port, exp, name);
        z80_rd_end();
    endtask

    task automatic z80_in_unmapped(input logic [7:0] port);
        @(negedge clk);
        z80_address_bus   = port;
        z80_ioreq_b       = 1'b0;
        z80_read_strobe_b = 1'b0;
        repeat (5) @(negedge clk);
        check("z80_unmapped_dir", 32'(z80_bus_dir), 32'd0);
        z80_rd_end();
    endtask

    // Directed sequence
    initial begin
        logic seen_ack;
        reset_b            = 1'b0;
        z80_write_strobe_b = 1'b1;
        z80_read_strobe_b  = 1'b1;
        z80_ioreq_b        = 1'b1;
        z80_m1             = 1'b1;
        z80_address_bus    = 8'h00;
        z80_data_bus_in    = 8'h00;
        wb_cyc_in          = 1'b0;
        wb_stb_in          = 1'b0;
        wb_we_in           = 1'b0;
        wb_addr_in         = 32'h0;
        wb_data_in         = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_z80_int_b", 32'(z80_int_b), 32'd1);
        check("rst_bus_dir", 32'(z80_bus_dir), 32'd0);
        check("rst_irq", 32'(irq_out), 32'd0);
        check("rst_ack", 32'(wb_ack_out), 32'd0);
        check("rst_wb_data", wb_data_out, 32'h0);
        check("rst_z80_data", 32'(z80_data_bus_out), 32'h0);
        reset_b = 1'b1;
        wb_read(5'h00, 32'h80, "cfg_reset");
        wb_read(5'h04, 32'h0, "status_reset");

        // Z80 -> WB byte, pending and irq
        z80_out(8'h80, 8'h5A);
        wb_read(5'h08, 32'h01, "pending_after_out");
        wb_read(5'h10, 32'h5A, "wb_pop_5a");
        wb_read(5'h10, 32'hFF, "wb_pop_empty");
        wb_write(5'h0C, 32'h01);
        repeat (2) @(negedge clk);
        check("irq_enabled", 32'(irq_out), 32'd1);
        wb_write(5'h08, 32'h01);
        repeat (2) @(negedge clk);
        check("irq_after_w1c", 32'(irq_out), 32'd0);
        wb_read(5'h08, 32'h00, "pending_after_w1c");

        // Fill a2z[1], overflow, drain from the Z80 side
        for (int i = 0; i < 16; i++) wb_write(5'h14, 32'h10 + i);
        wb_read(5'h04, 32'h020, "status_a2z1_full");
        wb_write(5'h14, 32'hEE);
        wb_read(5'h04, 32'h220, "status_ovf1");
        z80_in(8'h82, 8'h02, "z80_status_full");
        for (int i = 0; i < 16; i++) z80_in(8'h81, 8'(8'h10 + i), "z80_a2z1_order");
        wb_read(5'h08, 32'h20, "pending_a2z1_popped");
        wb_read(5'h04, 32'h200, "status_after_drain");

        // Underflow, unmapped port, error clear
        z80_in(8'h80, 8'hFF, "z80_underflow_ff");
        wb_read(5'h04, 32'h1200, "status_unf0");
        z80_in_unmapped(8'h90);
        wb_write(5'h08, 32'h0001_00FF);
        wb_read(5'h04, 32'h0, "status_err_cleared");
        wb_read(5'h08, 32'h0, "pending_cleared");

        // Z80 interrupt
        wb_write(5'h00, 32'h180);
        wb_read(5'h00, 32'h180, "cfg_int_en");
        wb_write(5'h10, 32'h77);
        repeat (3) @(negedge clk);
        check("z80_int_asserted", 32'(z80_int_b), 32'd0);
        z80_rd_start(8'h80, 8'h77, "z80_int_byte");
        check("z80_int_held_in_read", 32'(z80_int_b), 32'd0);
        z80_rd_end();
        check("z80_int_released", 32'(z80_int_b), 32'd1);

        // Base change while a read is in flight still pops the original channel
        wb_write(5'h08, 32'hFF);
        wb_write(5'h10, 32'h33);
        z80_rd_start(8'h80, 8'h33, "z80_read_before_rebase");
        wb_write(5'h00, 32'h040);
        z80_rd_end();
        wb_read(5'h08, 32'h10, "pending_rebase_pop");
        z80_in(8'h40, 8'hFF, "z80_new_base_empty");
        wb_read(5'h04, 32'h1000, "status_unf_new_base");
        wb_write(5'h00, 32'h080);
        wb_write(5'h08, 32'h0001_00FF);

        // Simultaneous Z80 push and WB pop on z2a[0]
        z80_out(8'h80, 8'hA1);
        z80_out(8'h80, 8'hA2);
        wb_read(5'h04, 32'h1, "status_z2a0_ne");
        fork
            z80_out(8'h80, 8'hA3);
            begin
                @(negedge clk);
                wb_read(5'h10, 32'hA1, "wb_pop_concurrent");
            end
        join
        wb_read(5'h10, 32'hA2, "wb_pop_a2");
        wb_read(5'h10, 32'hA3, "wb_pop_a3");
        wb_read(5'h10, 32'hFF, "wb_pop_drained");
        wb_read(5'h04, 32'h0, "status_after_concurrent");

        // Out-of-window and unused offsets
        @(negedge clk);
        wb_cyc_in  = 1'b1;
        wb_stb_in  = 1'b1;
        wb_addr_in = 32'h3000_0020;
        seen_ack   = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            seen_ack = seen_ack | wb_ack_out;
        end
        check("wb_out_of_window_noack", 32'(seen_ack), 32'd0);
        wb_cyc_in = 1'b0;
        wb_stb_in = 1'b0;
        wb_read(5'h18, 32'h0, "wb_unused_ch2");
        wb_read(5'h1C, 32'h0, "wb_unused_ch3");

        // Reset in the middle of a Z80 read
        wb_write(5'h14, 32'h99);
        z80_rd_start(8'h81, 8'h99, "z80_read_before_reset");
        #2;
        reset_b = 1'b0;
        #1;
        check("reset_dir_immediate", 32'(z80_bus_dir), 32'd0);
        z80_read_strobe_b = 1'b1;
        z80_ioreq_b       = 1'b1;
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        check("reset_z80_int_b", 32'(z80_int_b), 32'd1);
        wb_read(5'h00, 32'h80, "cfg_after_reset");
        wb_read(5'h04, 32'h0, "status_after_reset");
        z80_in(8'h82, 8'h00, "z80_status_after_reset");
        z80_in(8'h81, 8'hFF, "z80_a2z1_empty_after_reset");

        repeat (4) @(negedge clk);
        check("wb_exp_q_drained", wb_exp_q.size(), 0);
        check("z80_exp_q_drained", z80_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
